// File: rtl/cnn_pkg.sv
// Shared CNN pipeline constants.
// Layer shapes and pixel width are defined here so that conv1, pool1_relu
// and conv2_buf are always built with the same geometry.
package cnn_pkg;

    // Signed two's-complement pixel width used between layers.
    localparam int DATA_BITS      = 12;

    // conv1 output geometry (the input geometry of pool1_relu).
    localparam int CONV1_OUT_W    = 24;
    localparam int CONV1_OUT_H    = 24;
    localparam int CONV1_CHANNELS = 3;

    // pool1 output geometry (the input geometry of conv2_buf).
    localparam int POOL1_OUT_W    = CONV1_OUT_W / 2;
    localparam int POOL1_OUT_H    = CONV1_OUT_H / 2;

    // Signed maximum of two pixels. On a tie either operand is returned;
    // both carry the same value, so the choice is irrelevant.
    function automatic logic signed [DATA_BITS-1:0] smax(
        input logic signed [DATA_BITS-1:0] a,
        input logic signed [DATA_BITS-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool1_relu_lane.sv
// pool1_relu_lane: datapath for one channel of the 2x2/stride-2 max-pool + ReLU.
//
// Ports:
//   clk, rst_n  clock, synchronous active-low reset (clears pix_out only)
//   h_even      load hold register with pix_in (valid pixel in an even column)
//   write_en    store the horizontal max in the line buffer (even row, odd col)
//   out_en      produce a pooled output (odd row, odd col)
//   addr        line-buffer slot, i.e. input column >> 1
//   pix_in      signed input pixel for this channel
//   pix_out     registered pooled + ReLU'd pixel; holds its value between outputs
module pool1_relu_lane #(
    parameter int DATA_BITS = 12,
    parameter int HALF_W    = 12,
    parameter int ADDR_W    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        h_even,
    input  logic                        write_en,
    input  logic                        out_en,
    input  logic [ADDR_W-1:0]           addr,
    input  logic signed [DATA_BITS-1:0] pix_in,
    output logic signed [DATA_BITS-1:0] pix_out
);

    logic signed [DATA_BITS-1:0] hold_q, hold_d;
    logic signed [DATA_BITS-1:0] out_q, out_d;
    logic signed [DATA_BITS-1:0] lb_q [HALF_W];

    logic signed [DATA_BITS-1:0] hmax;
    logic signed [DATA_BITS-1:0] lb_rd;
    logic signed [DATA_BITS-1:0] pooled;

    always_comb begin
        hold_d = hold_q;
        out_d  = out_q;

        if (h_even) begin
            hold_d = pix_in;
        end

        // Horizontal pair max; only meaningful on an odd column, which is the
        // only time write_en/out_en can be asserted.
        hmax   = cnn_pkg::smax(hold_q, pix_in);
        // Rows alternate strictly between writing (even) and reading (odd),
        // so the read never sees a same-row write.
        lb_rd  = lb_q[addr];
        pooled = cnn_pkg::smax(lb_rd, hmax);

        if (out_en) begin
            out_d = pooled[DATA_BITS-1] ? '0 : pooled;
        end
    end

    // Hold register and line buffer carry no reset: every entry is rewritten
    // before it is read in each frame.
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
        if (write_en) begin
            lb_q[addr] <= hmax;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign pix_out = out_q;

endmodule

// File: rtl/pool1_relu.sv
// pool1_relu: streaming 2x2/stride-2 max-pool followed by ReLU, CHANNELS lanes
// in lockstep, sitting between the conv1 output stream and conv2_buf.
//
// Stream protocol (both sides): valid-only. A pixel transfers on every clock
// edge where its valid is high; there is no ready, the consumer is always able
// to accept. valid_in may drop for any number of cycles between any two pixels.
//
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   valid_in    data_in carries one pixel per channel this cycle
//   data_in     channel c at [c*DATA_BITS +: DATA_BITS], signed, raster order
//   data_out    pooled, ReLU'd pixel per channel (same packing), always >= 0
//   valid_out   data_out valid this cycle, 1 cycle after the window's last pixel
//   frame_done  pulses with the final valid_out of a frame
module pool1_relu #(
    parameter int DATA_BITS = cnn_pkg::DATA_BITS,
    parameter int IN_WIDTH  = cnn_pkg::CONV1_OUT_W,
    parameter int IN_HEIGHT = cnn_pkg::CONV1_OUT_H,
    parameter int CHANNELS  = cnn_pkg::CONV1_CHANNELS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          valid_in,
    input  logic [CHANNELS*DATA_BITS-1:0] data_in,
    output logic [CHANNELS*DATA_BITS-1:0] data_out,
    output logic                          valid_out,
    output logic                          frame_done
);

    localparam int COL_W  = $clog2(IN_WIDTH);
    localparam int ROW_W  = $clog2(IN_HEIGHT);
    localparam int ADDR_W = COL_W - 1;
    localparam int HALF_W = IN_WIDTH / 2;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(IN_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IN_HEIGHT - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             valid_out_q, valid_out_d;
    logic             frame_done_q, frame_done_d;

    // Column/row LSBs are the window phase: bit 0 of col selects the left or
    // right pixel, bit 0 of row selects the top (buffered) or bottom row.
    logic              h_even;
    logic              write_en;
    logic              out_en;
    logic              last_px;
    logic [ADDR_W-1:0] addr;

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;

        h_even       = valid_in & ~col_q[0];
        write_en     = valid_in &  col_q[0] & ~row_q[0];
        out_en       = valid_in &  col_q[0] &  row_q[0];
        last_px      = (col_q == LAST_COL) && (row_q == LAST_ROW);
        addr         = col_q[COL_W-1:1];

        valid_out_d  = out_en;
        frame_done_d = out_en & last_px;

        if (valid_in) begin
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        pool1_relu_lane #(
            .DATA_BITS (DATA_BITS),
            .HALF_W    (HALF_W),
            .ADDR_W    (ADDR_W)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .h_even   (h_even),
            .write_en (write_en),
            .out_en   (out_en),
            .addr     (addr),
            .pix_in   (data_in[g*DATA_BITS +: DATA_BITS]),
            .pix_out  (data_out[g*DATA_BITS +: DATA_BITS])
        );
    end

    assign valid_out  = valid_out_q;
    assign frame_done = frame_done_q;

endmodule
